// File: rtl/bram_dp_pipelined.sv
// ----------------------------------------------------------------------------
// bram_dp_pipelined
//   Dual-port synchronous block RAM. Port A does reads and byte-enabled writes,
//   port B is read-only. Both ports share CLK. After reset, or on init_req,
//   an internal sequencer writes zero to every word. User accesses are
//   dropped while that runs.
//
//   Read latency is 1 + OUT_REG cycles. Each accepted access gives a
//   one-cycle vld pulse. do_x holds its last value between pulses.
//
//   RDW_MODE selects what port A returns for a write:
//     0 = old word, 1 = merged new word, 2 = nothing (no vld).
//   Port B always returns the pre-write word. It raises collision together
//   with vld_b when an A write hits the same address on the same edge.
//
// Ports
//   CLK, RSTn              clock, async active-low reset
//   init_req / busy        clear request / clear in progress
//   en_a, we_a, addr_a,    port A enable, byte write enables (0 = read),
//   di_a, do_a, vld_a      address, write data, read data, valid
//   en_b, addr_b,          port B enable and address,
//   do_b, vld_b            read data, valid
//   collision              same-address A-write / B-read strobe
// ----------------------------------------------------------------------------
module bram_dp_pipelined #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 6,
    parameter int OUT_REG  = 1,
    parameter int RDW_MODE = 0,
    parameter int NBYTE    = DATA_W / 8
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              init_req,
    output logic              busy,
    input  logic              en_a,
    input  logic [NBYTE-1:0]  we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] di_a,
    output logic [DATA_W-1:0] do_a,
    output logic              vld_a,
    input  logic              en_b,
    input  logic [ADDR_W-1:0] addr_b,
    output logic [DATA_W-1:0] do_b,
    output logic              vld_b,
    output logic              collision
);

    localparam int   DEPTH   = 2 ** ADDR_W;
    localparam logic S_CLEAR = 1'b0;
    localparam logic S_READY = 1'b1;

    // ------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------
    logic              state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == S_CLEAR) begin
            // The counter wraps to 0 on the last word. This leaves it ready
            // for the next clear.
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == {ADDR_W{1'b1}}) begin
                state_d = S_READY;
            end
        end else if (init_req) begin
            state_d = S_CLEAR;
            cnt_d   = '0;
        end
        busy_d = (state_d == S_CLEAR);
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign busy = busy_q;

    // ------------------------------------------------------------------
    // Array and access acceptance
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              acc_a, acc_b, wr_a;
    logic [DATA_W-1:0] rd_a, rd_b, merged_a;

    assign acc_a = en_a & ~busy_q;
    assign acc_b = en_b & ~busy_q;
    assign wr_a  = acc_a & (|we_a);
    assign rd_a  = mem_q[addr_a];
    assign rd_b  = mem_q[addr_b];

    always_comb begin
        merged_a = rd_a;
        for (int i = 0; i < NBYTE; i++) begin
            if (we_a[i]) merged_a[8*i +: 8] = di_a[8*i +: 8];
        end
    end

    // The clear owns the write port while busy. User writes are blocked then
    // by acc_a, so there is only ever one writer.
    always_ff @(posedge CLK) begin
        if (busy_q) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_a) begin
            mem_q[addr_a] <= merged_a;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: array read register
    // ------------------------------------------------------------------
    logic              s1_vld_a_q, s1_vld_a_d, s1_vld_b_q, s1_vld_b_d;
    logic              s1_col_q, s1_col_d;
    logic [DATA_W-1:0] s1_dat_a_q, s1_dat_a_d, s1_dat_b_q, s1_dat_b_d;

    always_comb begin
        s1_vld_a_d = acc_a & ~(wr_a & (RDW_MODE == 2));
        s1_dat_a_d = s1_dat_a_q;
        if (s1_vld_a_d) begin
            s1_dat_a_d = (wr_a && RDW_MODE == 1) ? merged_a : rd_a;
        end
        s1_vld_b_d = acc_b;
        s1_dat_b_d = acc_b ? rd_b : s1_dat_b_q;
        s1_col_d   = acc_b & wr_a & (addr_a == addr_b);
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            s1_vld_a_q <= 1'b0;
            s1_vld_b_q <= 1'b0;
            s1_col_q   <= 1'b0;
            s1_dat_a_q <= '0;
            s1_dat_b_q <= '0;
        end else begin
            s1_vld_a_q <= s1_vld_a_d;
            s1_vld_b_q <= s1_vld_b_d;
            s1_col_q   <= s1_col_d;
            s1_dat_a_q <= s1_dat_a_d;
            s1_dat_b_q <= s1_dat_b_d;
        end
    end

    // ------------------------------------------------------------------
    // Optional stage 2: output register, loads only on stage-1 valid
    // ------------------------------------------------------------------
    if (OUT_REG != 0) begin : g_oreg
        logic              vld_a_q, vld_b_q, col_q;
        logic [DATA_W-1:0] do_a_q, do_a_d, do_b_q, do_b_d;

        always_comb begin
            do_a_d = s1_vld_a_q ? s1_dat_a_q : do_a_q;
            do_b_d = s1_vld_b_q ? s1_dat_b_q : do_b_q;
        end

        always_ff @(posedge CLK or negedge RSTn) begin
            if (!RSTn) begin
                vld_a_q <= 1'b0;
                vld_b_q <= 1'b0;
                col_q   <= 1'b0;
                do_a_q  <= '0;
                do_b_q  <= '0;
            end else begin
                vld_a_q <= s1_vld_a_q;
                vld_b_q <= s1_vld_b_q;
                col_q   <= s1_col_q;
                do_a_q  <= do_a_d;
                do_b_q  <= do_b_d;
            end
        end

        assign do_a      = do_a_q;
        assign do_b      = do_b_q;
        assign vld_a     = vld_a_q;
        assign vld_b     = vld_b_q;
        assign collision = col_q;
    end else begin : g_noreg
        assign do_a      = s1_dat_a_q;
        assign do_b      = s1_dat_b_q;
        assign vld_a     = s1_vld_a_q;
        assign vld_b     = s1_vld_b_q;
        assign collision = s1_col_q;
    end

endmodule

// File: tb/tb_bram_dp_pipelined.sv
// Bench for bram_dp_pipelined. It drives three instances from shared stimulus:
//   u0: OUT_REG=1, READ_FIRST
//   u1: OUT_REG=0, WRITE_FIRST
//   u2: OUT_REG=1, NO_CHANGE
// A reference memory pushes timestamped expectations for every stream. Every
// falling edge pops and compares them, including vld=0 and held data.
module tb_bram_dp_pipelined;
    localparam int DW = 16, AW = 6, NB = 2, DEPTH = 64;

    typedef struct {
        int          due;
        logic [15:0] dat;
        logic        col;
    } exp_t;

    typedef struct {
        logic [5:0]  addr;
        logic [1:0]  we;
        logic [15:0] di;
        logic [15:0] exp;
    } vec_t;

    logic          CLK = 1'b0, RSTn = 1'b1;
    logic          init_req = 1'b0, en_a = 1'b0, en_b = 1'b0;
    logic [NB-1:0] we_a = '0;
    logic [AW-1:0] addr_a = '0, addr_b = '0;
    logic [DW-1:0] di_a = '0;

    logic          busy0, busy1, busy2, vld_a0, vld_a1, vld_a2, vld_b0, vld_b1, vld_b2;
    logic          col0, col1, col2;
    logic [DW-1:0] do_a0, do_a1, do_a2, do_b0, do_b1, do_b2;

    int checks = 0, errors = 0;

    always #5 CLK = ~CLK;

    bram_dp_pipelined #(.DATA_W(DW), .ADDR_W(AW), .OUT_REG(1), .RDW_MODE(0)) u0 (
        .CLK(CLK), .RSTn(RSTn), .init_req(init_req), .busy(busy0),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .di_a(di_a), .do_a(do_a0), .vld_a(vld_a0),
        .en_b(en_b), .addr_b(addr_b), .do_b(do_b0), .vld_b(vld_b0), .collision(col0));
    bram_dp_pipelined #(.DATA_W(DW), .ADDR_W(AW), .OUT_REG(0), .RDW_MODE(1)) u1 (
        .CLK(CLK), .RSTn(RSTn), .init_req(init_req), .busy(busy1),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .di_a(di_a), .do_a(do_a1), .vld_a(vld_a1),
        .en_b(en_b), .addr_b(addr_b), .do_b(do_b1), .vld_b(vld_b1), .collision(col1));
    bram_dp_pipelined #(.DATA_W(DW), .ADDR_W(AW), .OUT_REG(1), .RDW_MODE(2)) u2 (
        .CLK(CLK), .RSTn(RSTn), .init_req(init_req), .busy(busy2),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .di_a(di_a), .do_a(do_a2), .vld_a(vld_a2),
        .en_b(en_b), .addr_b(addr_b), .do_b(do_b2), .vld_b(vld_b2), .collision(col2));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model and scoreboard
    // Streams: 0..2 = port A of u0..u2, 3..5 = port B of u0..u2.
    // ------------------------------------------------------------------
    logic [15:0] mdl_mem [DEPTH];
    exp_t        sq [6][$];
    logic [15:0] last [6];
    int          clr_left = DEPTH;
    int          cyc = 0;
    string       snm [6] = '{"a0", "a1", "a2", "b0", "b1", "b2"};
    int          lat [6] = '{2, 1, 2, 2, 1, 2};

    always @(negedge CLK or negedge RSTn) begin
        logic        av [6];
        logic        ac [6];
        logic [15:0] ad [6];
        logic [15:0] old_a, old_b, mrg;
        exp_t        e;
        bit          h, wr, col;
        if (!CLK) begin
            cyc++;
            av = '{vld_a0, vld_a1, vld_a2, vld_b0, vld_b1, vld_b2};
            ad = '{do_a0, do_a1, do_a2, do_b0, do_b1, do_b2};
            ac = '{1'b0, 1'b0, 1'b0, col0, col1, col2};
            chk("busy0", 32'(busy0), 32'(clr_left > 0));
            chk("busy1", 32'(busy1), 32'(clr_left > 0));
            chk("busy2", 32'(busy2), 32'(clr_left > 0));
            for (int s = 0; s < 6; s++) begin
                h = 0;
                e = '{0, 16'h0, 1'b0};
                if (sq[s].size() > 0 && sq[s][0].due == cyc) begin
                    e = sq[s].pop_front();
                    h = 1;
                end
                chk({snm[s], " vld"}, 32'(av[s]), 32'(h));
                if (h) last[s] = e.dat;
                chk({snm[s], " do"}, 32'(ad[s]), 32'(last[s]));
                if (s >= 3) chk({snm[s], " col"}, 32'(ac[s]), 32'(h & e.col));
            end
        end
        if (!RSTn) begin
            for (int s = 0; s < 6; s++) begin
                sq[s].delete();
                last[s] = 16'h0;
            end
            clr_left = DEPTH;
        end else if (!CLK) begin
            // Model the coming rising edge using the inputs held stable now.
            if (clr_left > 0) begin
                mdl_mem[DEPTH - clr_left] = 16'h0;
                clr_left--;
            end else begin
                wr  = en_a && (we_a != 0);
                mrg = 16'h0;
                if (en_a) begin
                    old_a = mdl_mem[addr_a];
                    mrg   = {we_a[1] ? di_a[15:8] : old_a[15:8], we_a[0] ? di_a[7:0] : old_a[7:0]};
                    sq[0].push_back('{cyc + lat[0], old_a, 1'b0});
                    sq[1].push_back('{cyc + lat[1], wr ? mrg : old_a, 1'b0});
                    if (!wr) sq[2].push_back('{cyc + lat[2], old_a, 1'b0});
                end
                if (en_b) begin
                    old_b = mdl_mem[addr_b];
                    col   = wr && (addr_a == addr_b);
                    for (int s = 3; s < 6; s++) sq[s].push_back('{cyc + lat[s], old_b, col});
                end
                if (wr) mdl_mem[addr_a] = mrg;
                if (init_req) clr_left = DEPTH;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (busy0 && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic wr_a(input logic [5:0] a, input logic [1:0] we, input logic [15:0] d);
        en_a = 1'b1; we_a = we; addr_a = a; di_a = d;
        tick();
        en_a = 1'b0; we_a = '0;
    endtask

    vec_t tbl [7];
    int   n;

    initial begin
        tbl[0] = '{6'd10, 2'b11, 16'h1111, 16'h1111};
        tbl[1] = '{6'd10, 2'b10, 16'hABCD, 16'hAB11};
        tbl[2] = '{6'd10, 2'b00, 16'hFFFF, 16'hAB11};
        tbl[3] = '{6'd63, 2'b01, 16'h00C3, 16'h00C3};
        tbl[4] = '{6'd63, 2'b10, 16'h7E00, 16'h7EC3};
        tbl[5] = '{6'd0,  2'b11, 16'hFFFF, 16'hFFFF};
        tbl[6] = '{6'd0,  2'b01, 16'h0000, 16'hFF00};

        // Reset and the clear that follows it.
        tick();
        RSTn = 1'b0;
        tick();
        chk("rst busy", 32'(busy0), 32'd1);
        chk("rst vld_a", 32'(vld_a0), 32'd0);
        chk("rst do_b", 32'(do_b0), 32'd0);
        RSTn = 1'b1;
        wait_ready(n);
        chk("busy_len_reset", 32'(n), 32'd64);

        // Reads after the clear. vld_a arrives two cycles after acceptance.
        foreach (tbl[i]) begin end
        for (int i = 0; i < 3; i++) begin
            en_a = 1'b1; we_a = 2'b00; addr_a = (i == 0) ? 6'd0 : (i == 1) ? 6'd31 : 6'd63;
            tick();
            en_a = 1'b0;
            chk("clr rd vld early", 32'(vld_a0), 32'd0);
            tick();
            chk("clr rd vld", 32'(vld_a0), 32'd1);
            chk("clr rd do", 32'(do_a0), 32'h0);
        end

        // Byte-enable write, and port A behaviour on a write in each mode.
        wr_a(6'd5, 2'b11, 16'hBEEF);
        en_a = 1'b1; we_a = 2'b01; addr_a = 6'd5; di_a = 16'h1234;
        tick();
        en_a = 1'b0; we_a = '0;
        chk("wf vld", 32'(vld_a1), 32'd1);
        chk("wf do", 32'(do_a1), 32'hBE34);
        tick();
        chk("rf vld", 32'(vld_a0), 32'd1);
        chk("rf do", 32'(do_a0), 32'hBEEF);
        chk("nc vld", 32'(vld_a2), 32'd0);
        en_a = 1'b1; addr_a = 6'd5;
        tick();
        en_a = 1'b0;
        tick();
        chk("rd5 do", 32'(do_a0), 32'hBE34);

        // Table: byte-enabled write, then read back through u0.
        for (int i = 0; i < 7; i++) begin
            wr_a(tbl[i].addr, tbl[i].we, tbl[i].di);
            en_a = 1'b1; we_a = 2'b00; addr_a = tbl[i].addr;
            tick();
            en_a = 1'b0;
            tick();
            chk($sformatf("tbl%0d", i), 32'(do_a0), 32'(tbl[i].exp));
        end

        // Collision, then a clean re-read.
        wr_a(6'd9, 2'b11, 16'hAAAA);
        tick();
        en_a = 1'b1; we_a = 2'b11; addr_a = 6'd9; di_a = 16'h5555;
        en_b = 1'b1; addr_b = 6'd9;
        tick();
        en_a = 1'b0; we_a = '0;
        tick();
        en_b = 1'b0;
        chk("col do_b", 32'(do_b0), 32'hAAAA);
        chk("col vld_b", 32'(vld_b0), 32'd1);
        chk("col flag", 32'(col0), 32'd1);
        tick();
        chk("col re do_b", 32'(do_b0), 32'h5555);
        chk("col re flag", 32'(col0), 32'd0);

        // Streaming B reads under both output latencies.
        for (int i = 0; i < 4; i++) wr_a(6'(i), 2'b11, 16'(16'h10 + i));
        for (int i = 0; i < 6; i++) begin
            en_b = (i < 4); addr_b = 6'(i);
            tick();
            if (i < 4) chk("s1 vld", 32'(vld_b1), 32'd1);
            if (i < 4) chk("s1 do", 32'(do_b1), 32'(16'h10 + i));
            if (i >= 1 && i <= 4) chk("s2 vld", 32'(vld_b0), 32'd1);
            if (i >= 1 && i <= 4) chk("s2 do", 32'(do_b0), 32'(16'h10 + i - 1));
            if (i == 4) chk("s1 end", 32'(vld_b1), 32'd0);
            if (i == 5) chk("s2 end", 32'(vld_b0), 32'd0);
        end
        en_b = 1'b0;

        // Random mixed traffic over a small address window.
        for (int i = 0; i < 300; i++) begin
            en_a = 1'($urandom_range(0, 1)); we_a = 2'($urandom_range(0, 3));
            addr_a = 6'($urandom_range(0, 7)); di_a = 16'($urandom);
            en_b = 1'($urandom_range(0, 1)); addr_b = 6'($urandom_range(0, 7));
            tick();
        end
        en_a = 1'b0; en_b = 1'b0; we_a = '0;
        tick(); tick();

        // Fill with 0xFFFF, request a clear, and poke during busy.
        for (int i = 0; i < DEPTH; i++) wr_a(6'(i), 2'b11, 16'hFFFF);
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            en_a = 1'b1; we_a = 2'b00; addr_a = 6'(i); en_b = 1'b1; addr_b = 6'(i);
            if (i == 5) init_req = 1'b1;
            tick();
            init_req = 1'b0;
            chk("busy drop vld_a", 32'(vld_a0), 32'd0);
        end
        en_a = 1'b0; en_b = 1'b0;
        wait_ready(n);
        chk("busy_len_init", 32'(n + 10), 32'd64);
        for (int i = 0; i < DEPTH; i++) begin
            en_a = 1'b1; addr_a = 6'(i); en_b = 1'b1; addr_b = 6'(63 - i);
            tick();
        end
        en_a = 1'b0; en_b = 1'b0;
        tick(); tick();

        // Reset in the middle of a clear.
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        RSTn = 1'b0;
        #1;
        chk("mid-clr rst busy", 32'(busy0), 32'd1);
        tick(); tick();
        RSTn = 1'b1;
        wait_ready(n);
        chk("busy_len_rst1", 32'(n), 32'd64);

        // Reset while reads are in flight.
        for (int i = 0; i < 8; i++) wr_a(6'(i), 2'b11, 16'(16'h100 + i));
        for (int i = 0; i < 3; i++) begin
            en_a = 1'b1; we_a = 2'b00; addr_a = 6'(i); en_b = 1'b1; addr_b = 6'(7 - i);
            tick();
        end
        en_a = 1'b0; en_b = 1'b0;
        RSTn = 1'b0;
        #1;
        chk("flight vld_a", 32'(vld_a0), 32'd0);
        chk("flight vld_b", 32'(vld_b0), 32'd0);
        chk("flight do_b", 32'(do_b0), 32'd0);
        tick();
        chk("flight vld_b later", 32'(vld_b0), 32'd0);
        RSTn = 1'b1;
        wait_ready(n);
        chk("busy_len_rst2", 32'(n), 32'd64);
        tick(); tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
